// File: rtl/dmem_ctrl_pkg.sv
// Shared types and lane helpers for the data-memory access controller.
package dmem_ctrl_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned HALF_W = 16;
   localparam int unsigned OFF_W  = 2;
   localparam int unsigned LSB_W  = 5;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2,
      SZ_RSVD = 2'd3
   } size_e;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      WRITE,
      RMW_RD,
      RMW_WR,
      RESP,
      DUMP,
      HALTED
   } state_e;

   // Big-endian lanes: byte offset 0 sits at bits [31:24], offset 3 at [7:0].
   function automatic logic [LSB_W-1:0] byte_lsb(input logic [OFF_W-1:0] off);
      return {~off, 3'b000};
   endfunction

   function automatic logic [LSB_W-1:0] half_lsb(input logic off_hi);
      return {~off_hi, 4'b0000};
   endfunction

   function automatic logic req_bad(input size_e sz, input logic [OFF_W-1:0] off);
      logic bad;
      case (sz)
         SZ_HALF: bad = off[0];
         SZ_WORD: bad = (off != 2'b00);
         SZ_RSVD: bad = 1'b1;
         default: bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/dmem_lane.sv
// Lane extract/extend for loads and lane merge for sub-word stores.
module dmem_lane
   import dmem_ctrl_pkg::*;
(
   input  logic [1:0]  offset,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merged
);

   logic [LSB_W-1:0]  b_lsb;
   logic [LSB_W-1:0]  h_lsb;
   logic [BYTE_W-1:0] byte_v;
   logic [HALF_W-1:0] half_v;

   always_comb begin
      b_lsb     = byte_lsb(offset);
      h_lsb     = half_lsb(offset[1]);
      byte_v    = word[b_lsb +: BYTE_W];
      half_v    = word[h_lsb +: HALF_W];
      load_data = word;
      merged    = word;
      case (size_e'(size))
         SZ_BYTE: begin
            load_data = {{(DATA_W-BYTE_W){sign_ext & byte_v[BYTE_W-1]}}, byte_v};
            merged[b_lsb +: BYTE_W] = wdata[BYTE_W-1:0];
         end
         SZ_HALF: begin
            load_data = {{(DATA_W-HALF_W){sign_ext & half_v[HALF_W-1]}}, half_v};
            merged[h_lsb +: HALF_W] = wdata[HALF_W-1:0];
         end
         default: merged = wdata;
      endcase
   end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory initiator: CPU load/store handshake, sub-word read-modify-write,
// load extension and end-of-run dump sequencing.
module dmem_ctrl
   import dmem_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wr,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   input  logic        halt_req,
   output logic        halt_done,
   output logic        mem_enable,
   output logic        mem_wr,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        mem_createdump
);

   state_e            state;
   logic [OFF_W-1:0]  cap_off;
   logic [1:0]        cap_size;
   logic              cap_signed;
   logic [DATA_W-1:0] cap_wdata;
   logic [DATA_W-1:0] load_data;
   logic [DATA_W-1:0] merged;

   assign req_ready = (state == IDLE) & ~halt_req & ~rst;

   dmem_lane u_lane (
      .offset    (cap_off),
      .size      (cap_size),
      .sign_ext  (cap_signed),
      .word      (mem_rdata),
      .wdata     (cap_wdata),
      .load_data (load_data),
      .merged    (merged)
   );

   // Single registered FSM; every memory strobe is a flop so it is glitch-free.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         cap_off        <= '0;
         cap_size       <= '0;
         cap_signed     <= 1'b0;
         cap_wdata      <= '0;
         resp_valid     <= 1'b0;
         resp_rdata     <= '0;
         resp_err       <= 1'b0;
         halt_done      <= 1'b0;
         mem_enable     <= 1'b0;
         mem_wr         <= 1'b0;
         mem_addr       <= '0;
         mem_wdata      <= '0;
         mem_createdump <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (halt_req) begin
                  mem_createdump <= 1'b1;
                  state          <= DUMP;
               end else if (req_valid) begin
                  cap_off    <= req_addr[OFF_W-1:0];
                  cap_size   <= req_size;
                  cap_signed <= req_signed;
                  cap_wdata  <= req_wdata;
                  resp_rdata <= '0;
                  resp_err   <= 1'b0;
                  if (req_bad(size_e'(req_size), req_addr[OFF_W-1:0])) begin
                     resp_err   <= 1'b1;
                     resp_valid <= 1'b1;
                     state      <= RESP;
                  end else begin
                     mem_enable <= 1'b1;
                     mem_addr   <= {2'b00, req_addr[ADDR_W-1:OFF_W]};
                     if (!req_wr) begin
                        mem_wr <= 1'b0;
                        state  <= READ;
                     end else if (size_e'(req_size) == SZ_WORD) begin
                        mem_wr    <= 1'b1;
                        mem_wdata <= req_wdata;
                        state     <= WRITE;
                     end else begin
                        mem_wr <= 1'b0;
                        state  <= RMW_RD;
                     end
                  end
               end
            end
            READ: begin
               resp_rdata <= load_data;
               resp_valid <= 1'b1;
               mem_enable <= 1'b0;
               state      <= RESP;
            end
            RMW_RD: begin
               mem_wr    <= 1'b1;
               mem_wdata <= merged;
               state     <= RMW_WR;
            end
            WRITE, RMW_WR: begin
               mem_enable <= 1'b0;
               mem_wr     <= 1'b0;
               resp_valid <= 1'b1;
               state      <= RESP;
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  state      <= IDLE;
               end
            end
            DUMP: begin
               mem_createdump <= 1'b0;
               halt_done      <= 1'b1;
               state          <= HALTED;
            end
            HALTED: state <= HALTED;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: byte-array reference model, directed and random requests.
module tb_dmem_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_wr, req_signed;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;
   logic        halt_req, halt_done;
   logic        mem_enable, mem_wr, mem_createdump;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   logic [31:0] mem [64];
   logic [7:0]  ref_b [256];
   int          total = 0;
   int          bad = 0;
   int          en_cnt = 0;
   int          wr_cnt = 0;
   int          dump_cnt = 0;
   logic [31:0] last_idx = '0;

   always #5 clk = ~clk;

   dmem_ctrl dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err), .halt_req(halt_req),
      .halt_done(halt_done), .mem_enable(mem_enable), .mem_wr(mem_wr),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_createdump(mem_createdump)
   );

   // Single-cycle word memory stand-in plus activity counters.
   assign mem_rdata = mem[mem_addr[5:0]];

   always @(posedge clk) begin
      if (mem_createdump === 1'b1) dump_cnt++;
      if (mem_enable === 1'b1) begin
         en_cnt++;
         last_idx = mem_addr;
         if (mem_wr === 1'b1) begin
            wr_cnt++;
            mem[mem_addr[5:0]] = mem_wdata;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] ref_word(input int idx);
      return {ref_b[4*idx], ref_b[4*idx+1], ref_b[4*idx+2], ref_b[4*idx+3]};
   endfunction

   // Load modelled as big-endian byte concatenation, then extension.
   function automatic logic [31:0] ref_load(input int addr, input int n, input bit sgn);
      logic [31:0] v = 0;
      for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_b[addr+i]);
      if (sgn && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
      return v;
   endfunction

   task automatic ref_store(input int addr, input int n, input logic [31:0] wd);
      for (int i = 0; i < n; i++) ref_b[addr+i] = 8'(wd >> (8*(n-1-i)));
   endtask

   task automatic txn(input bit wr, input bit [1:0] sz, input bit sgn,
                      input bit [31:0] addr, input bit [31:0] wd, input int stall);
      int n, lat, cyc, en0, wr0, exp_en;
      bit err;
      logic [31:0] exp_rd;
      n      = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      err    = (sz == 2'd3) || (int'(addr) % n != 0);
      exp_rd = (wr || err) ? 32'd0 : ref_load(int'(addr), n, sgn);
      lat    = err ? 1 : (wr && n < 4) ? 3 : 2;
      exp_en = err ? 0 : (wr && n < 4) ? 2 : 1;
      if (wr && !err) ref_store(int'(addr), n, wd);
      en0 = en_cnt;
      wr0 = wr_cnt;
      chk("req_ready_idle", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_wr = wr; req_size = sz; req_signed = sgn;
      req_addr = addr; req_wdata = wd;
      step();
      req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
      cyc = 1;
      while (resp_valid !== 1'b1 && cyc < 20) begin
         step();
         cyc++;
      end
      chk("latency", 32'(cyc), 32'(lat));
      chk("resp_rdata", resp_rdata, exp_rd);
      chk("resp_err", 32'(resp_err), 32'(err));
      chk("mem_enable_cycles", 32'(en_cnt - en0), 32'(exp_en));
      chk("mem_write_cycles", 32'(wr_cnt - wr0), (wr && !err) ? 32'd1 : 32'd0);
      if (!err) chk("mem_addr", last_idx, {2'b00, addr[31:2]});
      chk("mem_word", mem[addr[7:2]], ref_word(int'(addr[7:2])));
      for (int s = 0; s < stall; s++) begin
         step();
         chk("stall_valid", 32'(resp_valid), 32'd1);
         chk("stall_rdata", resp_rdata, exp_rd);
         chk("stall_ready", 32'(req_ready), 32'd0);
         chk("stall_mem_idle", 32'(en_cnt - en0), 32'(exp_en));
      end
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
      chk("resp_drop", 32'(resp_valid), 32'd0);
   endtask

   initial begin
      logic [31:0] w, w0;
      int en0, wr0;
      rst = 1'b1; req_valid = 0; req_wr = 0; req_size = 0; req_signed = 0;
      req_addr = 0; req_wdata = 0; resp_ready = 0; halt_req = 0;
      for (int i = 0; i < 64; i++) begin
         w = $urandom;
         mem[i] = w;
         for (int k = 0; k < 4; k++) ref_b[4*i+k] = 8'(w >> (24 - 8*k));
      end
      repeat (3) step();
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_mem_enable", 32'(mem_enable), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_dump_halt", {30'd0, mem_createdump, halt_done}, 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_ready", 32'(req_ready), 32'd1);

      // Directed scenarios.
      txn(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0);
      chk("word_store_mem", mem[4], 32'hDEADBEEF);
      txn(0, 2'd2, 0, 32'h10, 32'h0, 0);
      txn(1, 2'd2, 0, 32'h10, 32'h11223344, 0);
      txn(1, 2'd0, 0, 32'h11, 32'h000000AA, 0);
      chk("byte_rmw_mem", mem[4], 32'h11AA3344);
      txn(0, 2'd0, 1, 32'h11, 32'h0, 0);
      txn(0, 2'd0, 0, 32'h11, 32'h0, 0);
      txn(1, 2'd2, 0, 32'h10, 32'h11228344, 0);
      txn(0, 2'd1, 1, 32'h12, 32'h0, 0);
      txn(0, 2'd1, 0, 32'h13, 32'h0, 0);
      txn(1, 2'd3, 0, 32'h20, 32'h12345678, 0);
      txn(0, 2'd2, 1, 32'h12, 32'h0, 5);

      // Reset while the read half of a read-modify-write is in flight.
      w0 = mem[8]; en0 = en_cnt; wr0 = wr_cnt;
      req_valid = 1'b1; req_wr = 1'b1; req_size = 2'd1; req_signed = 1'b0;
      req_addr = 32'h22; req_wdata = 32'h0000BEEF;
      step();
      req_valid = 1'b0;
      chk("rmw_rd_enable", {30'd0, mem_enable, mem_wr}, 32'd2);
      rst = 1'b1;
      step();
      chk("abort_outputs", {27'd0, resp_valid, resp_err, mem_enable, mem_wr, mem_createdump}, 32'd0);
      chk("abort_addr_data", mem_addr | mem_wdata | resp_rdata, 32'd0);
      rst = 1'b0;
      repeat (3) step();
      chk("abort_no_write", 32'(wr_cnt - wr0), 32'd0);
      chk("abort_word", mem[8], w0);
      chk("abort_reads", 32'(en_cnt - en0), 32'd1);

      // Randomized traffic against the byte-array model.
      for (int t = 0; t < 60; t++) begin
         txn(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
             32'($urandom_range(0, 255)), $urandom, int'($urandom_range(0, 2)));
      end

      // Halt wins over a simultaneous request; controller stays stopped.
      en0 = en_cnt;
      halt_req = 1'b1; req_valid = 1'b1; req_wr = 1'b0; req_size = 2'd2; req_addr = 32'h0;
      #1;
      chk("halt_req_ready", 32'(req_ready), 32'd0);
      step();
      halt_req = 1'b0;
      chk("dump_pulse", {30'd0, mem_createdump, mem_enable}, 32'd2);
      chk("dump_no_resp", 32'(resp_valid), 32'd0);
      step();
      chk("dump_end", 32'(mem_createdump), 32'd0);
      chk("halted_done", 32'(halt_done), 32'd1);
      repeat (4) step();
      chk("halted_stays", {30'd0, halt_done, req_ready}, 32'd2);
      chk("halted_no_mem", 32'(en_cnt - en0), 32'd0);
      chk("dump_count", 32'(dump_cnt), 32'd1);
      req_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      chk("unhalt_done", 32'(halt_done), 32'd0);
      chk("unhalt_ready", 32'(req_ready), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
